// File: rtl/uart_imem_loader.sv
// UART byte receiver that streams bytes into the instruction memory write port.
// A 0xFE..0xFF bracketed load holds the CPU in reset and ends with flush strobes.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int STROBE_CYCLES = 2,
  parameter int FLUSH_STROBES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       wr_en_o,
  output logic       loading_o,
  output logic       done_o,
  output logic       cpu_reset_n_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FW = (FLUSH_STROBES < 1) ? 1 : $clog2(FLUSH_STROBES + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FW-1:0] FL_N     = FW'(FLUSH_STROBES);
  localparam logic [2:0]    S_N      = 3'(STROBE_CYCLES);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] O_IDLE = 3'd0;
  localparam logic [2:0] O_LOAD = 3'd1;
  localparam logic [2:0] O_HIGH = 3'd2;
  localparam logic [2:0] O_LOW  = 3'd3;
  localparam logic [2:0] O_DONE = 3'd4;

  logic          rx_s1_q, rx_s2_q;
  logic [1:0]    vld_q;
  logic          armed_q, armed_d;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bad_q, bad_d;
  logic          ferr_q, ferr_d;
  logic          rx_vld;

  logic [2:0]    ost_q, ost_d;
  logic [2:0]    scnt_q, scnt_d;
  logic [FW-1:0] fl_q, fl_d;
  logic          flush_q, flush_d;
  logic [7:0]    byte_q, byte_d;
  logic          wr_q, wr_d;
  logic          ld_q, ld_d;
  logic          dn_q, dn_d;
  logic [7:0]    buf_q, buf_d;
  logic          bufv_q, bufv_d;
  logic          load_en;
  logic [7:0]    load_b;

  // A line already low at reset release must be seen high before a frame starts
  assign armed_d = armed_q | (vld_q[1] & rx_s2_q);

  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bad_d   = bad_q;
    ferr_d  = ferr_q;
    rx_vld  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (armed_q && !rx_s2_q) begin
          rx_st_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          idx_d   = '0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s2_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bad_q) begin
          if (rx_s2_q) begin
            rx_st_d = RX_IDLE;
            bad_d   = 1'b0;
          end
        end else if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            rx_vld  = 1'b1;
            rx_st_d = RX_IDLE;
          end else begin
            bad_d  = 1'b1;
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    byte_d  = byte_q;
    wr_d    = wr_q;
    ost_d   = ost_q;
    scnt_d  = scnt_q;
    fl_d    = fl_q;
    flush_d = flush_q;
    ld_d    = ld_q;
    dn_d    = dn_q;
    buf_d   = buf_q;
    bufv_d  = bufv_q;
    load_en = 1'b0;
    load_b  = shift_q;
    // Bytes finishing while the strobe engine is busy wait in a 1-deep buffer
    if (ost_q == O_IDLE && (bufv_q || rx_vld)) begin
      load_en = 1'b1;
      load_b  = bufv_q ? buf_q : shift_q;
      bufv_d  = bufv_q & rx_vld;
      if (rx_vld) buf_d = shift_q;
    end else if (rx_vld) begin
      buf_d  = shift_q;
      bufv_d = 1'b1;
    end
    if (load_en) begin
      byte_d = load_b;
      ost_d  = O_LOAD;
      if (load_b == 8'hFE) begin
        ld_d = 1'b1;
        dn_d = 1'b0;
      end
      if (load_b == 8'hFF && ld_q) begin
        flush_d = 1'b1;
        fl_d    = FL_N;
      end
    end
    unique case (ost_q)
      O_LOAD: begin
        wr_d   = 1'b1;
        scnt_d = 3'd1;
        ost_d  = O_HIGH;
      end
      O_HIGH: begin
        if (scnt_q == S_N) begin
          wr_d   = 1'b0;
          scnt_d = 3'd1;
          if (flush_q) ost_d = (fl_q != '0) ? O_LOW : O_DONE;
          else         ost_d = O_IDLE;
        end else begin
          scnt_d = scnt_q + 3'd1;
        end
      end
      O_LOW: begin
        if (scnt_q == S_N) begin
          wr_d   = 1'b1;
          scnt_d = 3'd1;
          fl_d   = fl_q - 1'b1;
          ost_d  = O_HIGH;
        end else begin
          scnt_d = scnt_q + 3'd1;
        end
      end
      O_DONE: begin
        ld_d    = 1'b0;
        dn_d    = 1'b1;
        flush_d = 1'b0;
        ost_d   = O_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      vld_q   <= '0;
      armed_q <= 1'b0;
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      bad_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ost_q   <= O_IDLE;
      scnt_q  <= '0;
      fl_q    <= '0;
      flush_q <= 1'b0;
      byte_q  <= '0;
      wr_q    <= 1'b0;
      ld_q    <= 1'b0;
      dn_q    <= 1'b0;
      buf_q   <= '0;
      bufv_q  <= 1'b0;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_d;
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bad_q   <= bad_d;
      ferr_q  <= ferr_d;
      ost_q   <= ost_d;
      scnt_q  <= scnt_d;
      fl_q    <= fl_d;
      flush_q <= flush_d;
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      dn_q    <= dn_d;
      buf_q   <= buf_d;
      bufv_q  <= bufv_d;
    end
  end

  assign byte_o        = byte_q;
  assign wr_en_o       = wr_q;
  assign loading_o     = ld_q;
  assign done_o        = dn_q;
  assign cpu_reset_n_o = ~ld_q;
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: UART stimulus, strobe scoreboard,
// load/flush timing, framing, glitch and reset cases.
module tb_uart_imem_loader;

  localparam int CPB = 16;
  localparam int SC  = 2;
  localparam int FS  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_o;
  logic       wr_en_o, loading_o, done_o, cpu_reset_n_o, frame_err_o;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  logic [7:0] blog[$];
  int         rise_c[$];
  int         fall_c[$];
  int         cyc = 0;
  int         run = 0;
  int         nstb = 0;
  int         ld_fall = 0;
  logic       wr_prev = 1'b0;
  logic       ld_prev = 1'b0;

  uart_imem_loader #(
    .CLKS_PER_BIT (CPB),
    .STROBE_CYCLES(SC),
    .FLUSH_STROBES(FS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_i         (rx),
    .byte_o       (byte_o),
    .wr_en_o      (wr_en_o),
    .loading_o    (loading_o),
    .done_o       (done_o),
    .cpu_reset_n_o(cpu_reset_n_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    wr_prev <= wr_en_o;
    ld_prev <= loading_o;
    if (wr_en_o && !wr_prev) begin
      nstb <= nstb + 1;
      rise_c.push_back(cyc);
      blog.push_back(byte_o);
      run <= 1;
      chk("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("strobe_byte", 32'(byte_o), 32'(sb.pop_front()));
    end else if (wr_en_o) begin
      run <= run + 1;
    end
    if (!wr_en_o && wr_prev) begin
      chk("strobe_width", 32'(run), 32'(SC));
      fall_c.push_back(cyc);
    end
    if (!loading_o && ld_prev) ld_fall <= cyc;
  end

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (CPB) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || wr_en_o) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_byte"}, 32'(byte_o), 32'h00);
    chk({tag, "_wr"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_loading"}, 32'(loading_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_reset_n_o), 32'd1);
    chk({tag, "_ferr"}, 32'(frame_err_o), 32'd0);
  endtask

  initial begin
    int saved;
    logic [7:0] fe;
    logic [7:0] ld_seq[6];
    ld_seq = '{8'hFE, 8'h13, 8'h00, 8'h00, 8'h00, 8'hFF};

    repeat (4) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // single byte outside a load
    sb.push_back(8'h5A);
    send(8'h5A, 1'b1);
    drain("drain_5a");
    chk("5a_hold", 32'(byte_o), 32'h5A);
    chk("5a_loading", 32'(loading_o), 32'd0);
    chk("5a_ferr", 32'(frame_err_o), 32'd0);

    // short low glitch
    saved = nstb;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_nostrobe", 32'(nstb), 32'(saved));
    chk("glitch_ferr", 32'(frame_err_o), 32'd0);

    // framing error, then a good byte
    send(8'hA5, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr_nostrobe", 32'(nstb), 32'(saved));
    chk("ferr_set", 32'(frame_err_o), 32'd1);
    sb.push_back(8'h11);
    send(8'h11, 1'b1);
    drain("drain_11");
    chk("ferr_sticky", 32'(frame_err_o), 32'd1);

    // full load with flush
    rise_c.delete();
    fall_c.delete();
    blog.delete();
    for (int i = 0; i < 6; i++) begin
      sb.push_back(ld_seq[i]);
      if (ld_seq[i] == 8'hFF)
        for (int k = 0; k < FS; k++) sb.push_back(8'hFF);
      send(ld_seq[i], 1'b1);
      if (i == 0) begin
        chk("load_loading", 32'(loading_o), 32'd1);
        chk("load_cpurst", 32'(cpu_reset_n_o), 32'd0);
      end
    end
    drain("drain_load");
    repeat (3) @(negedge clk);
    chk("load_nstrobes", 32'(rise_c.size()), 32'd9);
    for (int i = 5; i < 8; i++)
      chk("flush_gap", 32'(rise_c[i+1] - fall_c[i]), 32'(SC));
    chk("load_end_lag", 32'(ld_fall - fall_c[8]), 32'd1);
    chk("load_word0", {blog[1], blog[2], blog[3], blog[4]}, 32'h13000000);
    chk("end_loading", 32'(loading_o), 32'd0);
    chk("end_done", 32'(done_o), 32'd1);
    chk("end_cpurst", 32'(cpu_reset_n_o), 32'd1);

    // 0xFF then 0x22 back to back inside a load
    sb.push_back(8'hFE);
    send(8'hFE, 1'b1);
    chk("reload_done_clr", 32'(done_o), 32'd0);
    sb.push_back(8'hFE);
    send(8'hFE, 1'b1);
    chk("fe_in_load", 32'(loading_o), 32'd1);
    for (int k = 0; k <= FS; k++) sb.push_back(8'hFF);
    sb.push_back(8'h22);
    send(8'hFF, 1'b1);
    send(8'h22, 1'b1);
    drain("drain_ff22");
    repeat (3) @(negedge clk);
    chk("ff22_last", 32'(byte_o), 32'h22);
    chk("ff22_done", 32'(done_o), 32'd1);

    // reset in the middle of a 0xFE frame
    saved = nstb;
    fe = 8'hFE;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = fe[i];
      repeat (CPB) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_nostrobe", 32'(nstb), 32'(saved));

    // line low across reset release must not start a frame
    reset_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("lowline_nostrobe", 32'(nstb), 32'(saved));
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1);
    drain("drain_3c");
    chk("lowline_one", 32'(nstb), 32'(saved + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 Parameter STROBE_CYCLES, default 2: number of cycles wr_en_o stays high per strobe; legal range 1..4.
REQ-003 Parameter FLUSH_STROBES, default 3: number of extra strobes issued after the end marker.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 rx_i  input  1  UART serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-007 byte_o  output  8  byte presented to the instruction memory byte input.
REQ-008 wr_en_o  output  1  write strobe to the instruction memory; the memory samples byte_o on its rising edge.
REQ-009 loading_o  output  1  high from the start marker 0xFE until flush completes.
REQ-010 done_o  output  1  high after a completed load; cleared by the next 0xFE.
REQ-011 cpu_reset_n_o  output  1  active-low hold for the CPU core; equals ~loading_o.
REQ-012 frame_err_o  output  1  sticky flag: a stop bit was sampled low.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-014 The RX FSM SHALL have states IDLE, START, DATA, STOP, using a bit-time counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index.
REQ-015 IDLE -> START on the synchronized rx falling to 0; the counter is cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1 (integer division), if rx is still 0 -> DATA with the counter cleared; if rx is 1 -> IDLE (glitch rejected, no error).
REQ-017 DATA: sample rx each time the counter reaches CLKS_PER_BIT-1 (mid-bit) into shift bit [index], LSB first; after index 7 -> STOP.
REQ-018 STOP: at mid-bit, if rx = 1 the byte is valid and the FSM goes to IDLE; if rx = 0, set frame_err_o, discard the byte, and stay in STOP until rx = 1, then go to IDLE.
REQ-019 Each valid byte SHALL be forwarded: byte_o loads the byte in cycle N, wr_en_o is high in cycles N+1 .. N+STROBE_CYCLES, and byte_o holds until the next load.
REQ-020 All valid bytes SHALL be forwarded, including 0xFE, 0xFF, and bytes received outside a load.
REQ-021 loading_o SHALL rise in the cycle byte_o loads 0xFE and clear done_o in the same cycle.
REQ-022 When 0xFF is forwarded while loading_o = 1, the block SHALL then issue FLUSH_STROBES more strobes with byte_o = 0xFF:
  - each strobe STROBE_CYCLES high, then STROBE_CYCLES low;
  - the first strobe begins STROBE_CYCLES cycles after the 0xFF strobe ends.
REQ-023 In the cycle after the last flush strobe falls, loading_o SHALL go to 0 and done_o to 1.
REQ-024 During a flush, the RX FSM SHALL keep running; a byte completed during the flush SHALL be held in a 1-entry buffer and forwarded after the flush.
  - A second byte arriving while the buffer is full overwrites it.
REQ-025 0xFF received while loading_o = 0 SHALL be forwarded as a single strobe with no flush.
REQ-026 0xFE received while loading_o = 1 SHALL be forwarded and leave loading_o at 1 (no restart).
REQ-027 wr_en_o SHALL be a registered output with no combinational path from rx_i.

Reset
REQ-028 While reset_n = 0:
  - byte_o = 0x00, wr_en_o = 0, loading_o = 0, done_o = 0, cpu_reset_n_o = 1, frame_err_o = 0;
  - RX FSM = IDLE, all counters = 0, buffer empty.
REQ-029 Reset asserted mid-frame or mid-flush SHALL abort immediately, with no further strobes after deassertion.
REQ-030 After reset deasserts, the block SHALL wait for a fresh start bit; a line already low SHALL not start a frame until it has been seen high.

Verification (CLKS_PER_BIT=16, STROBE_CYCLES=2, FLUSH_STROBES=3)
REQ-031 Send byte 0x5A -> byte_o = 0x5A, one wr_en_o pulse of 2 cycles, loading_o stays 0, frame_err_o = 0.
REQ-032 Send 0xFE,0x13,0x00,0x00,0x00,0xFF ->
  - 6 data strobes, then 3 flush strobes with byte_o = 0xFF;
  - loading_o and cpu_reset_n_o toggle as specified;
  - done_o = 1 at the end;
  - downstream memory word 0 = 0x13000000.
REQ-033 rx low for 6 cycles then high -> no strobe, FSM returns to IDLE, frame_err_o = 0.
REQ-034 Byte 0xA5 sent with stop bit = 0 -> no strobe, frame_err_o = 1 and sticky; the next good byte 0x11 is still forwarded.
REQ-035 Send 0xFF then, without gap, 0x22 during the flush -> 0x22 is forwarded after the third flush strobe.
REQ-036 Assert reset_n mid-DATA of byte 0xFE -> all outputs reach reset values within the same cycle; no strobe appears after release.
